pipe_interlock: RTL and testbench
=================================

// Module: pipe_interlock
// PURPOSE
//   Parametrised hazard/forwarding controller for the in-order 16-bit core pipeline.
//   Replaces the fixed two-source, three-stage hazard+forward pair.
//   Tracks the destination register of every in-flight instruction (EX..WB).
//   Returns per-source forward selects and a load-use stall for the instruction in ID.
//   Also provides flush, drain and stall-count functions.
// PARAMETERS
//   REG_AW    4   register index width (2**REG_AW architectural registers)
//   STAGES    3   tracked in-flight stages after ID (entry 0 = EX ... STAGES-1 = WB)
//   LOAD_LAT  2   a load's data is forwardable from entry k when k >= LOAD_LAT-1
//   ZERO_REG  1   1: register 0 is hardwired zero and never creates a hazard
//   FLUSH_EX  1   1: flush also kills entry 0 (EX); 0: flush kills only the ID instruction
//   CNT_W     16  width of the stall counter
// PORTS
//   clk         in   1          core clock
//   rst_n       in   1          asynchronous reset, active low
//   id_valid    in   1          ID holds a real instruction
//   id_rs       in   REG_AW     source A index
//   id_rt       in   REG_AW     source B index
//   id_rs_used  in   1          source A is read
//   id_rt_used  in   1          source B is read
//   id_rd       in   REG_AW     destination index
//   id_we       in   1          instruction writes id_rd
//   id_is_load  in   1          instruction is a load (data late by LOAD_LAT)
//   flush       in   1          taken branch/jump: squash per FLUSH_EX
//   stall       out  1          hold PC and IF/ID; bubble goes into EX
//   fwd_rs      out  SW         0 = register file, k+1 = result of entry k; SW = $clog2(STAGES+1)
//   fwd_rt      out  SW         same encoding as fwd_rs, for source B
//   drained     out  1          no valid entry in flight (halt may retire)
//   stall_cnt   out  CNT_W      cycles in which stall was asserted
// BEHAVIOUR
//   - State: STAGES entries {valid, rd, we, is_load}, shifted every cycle. Always
//     advances: entry k+1 <= entry k; the last entry retires.
//   - Entry 0 load value:
//       id_valid & ~stall & ~flush  -> {1, id_rd, id_we, id_is_load}
//       otherwise                   -> bubble (valid=0)
//     With FLUSH_EX=1 and flush high, the shift into entry 1 is also a bubble.
//   - Match, per used source s: valid & we & rd==s & ~(ZERO_REG & s==0).
//     The youngest match (lowest k) wins.
//   - fwd_x = k+1 of the youngest match; 0 if no match, source unused, or id_valid=0.
//   - Ready: an entry is ready if ~is_load, or if k >= LOAD_LAT-1.
//   - stall = id_valid & ~flush & (youngest match of either used source is not ready).
//     It is purely combinational from inputs and state.
//   - While stall is high, fwd_x still reflects the current match; the consumer ignores it.
//   - flush and stall together: flush wins, stall=0, and stall_cnt is not incremented.
//   - drained = no entry valid (combinational).
//   - stall_cnt increments on every clk edge where stall=1 and saturates at all-ones.
//   - Reset (async, rst_n low): all entries invalid and stall_cnt=0.
//     Hence stall=0, fwd_rs=fwd_rt=0, drained=1.
//     A reset mid-sequence discards all in-flight tracking immediately.
//   - No wrap-around in the shift. Indices are compared at full REG_AW width.
// TESTING
//   1. Reset: rst_n=0 -> stall=0, fwd=0, drained=1, stall_cnt=0.
//      Releasing reset with id_valid=0 keeps these values.
//   2. ALU chain: issue ADD r3 then SUB r4,r3,r5 next cycle -> fwd_rs=1, stall=0.
//      One cycle later with r3 in entry 1 -> fwd_rs=2.
//   3. Load-use: LW r2 then ADD r6,r2,r2 -> stall=1 for 1 cycle, stall_cnt=1.
//      Then fwd_rs=fwd_rt=2, stall=0.
//   4. r0 and priority: ADD r0 then use r0 -> fwd=0, no stall.
//      ADD r7 twice then use r7 -> fwd_rs=1 (youngest match wins).
//   5. Flush: LW r2 in entry 0, dependent in ID, flush=1 -> stall=0, entry 0 killed.
//      Next cycle a dependent on r2 gets fwd_rs=0.
//   6. Drain and saturation: issue 1 instruction, then id_valid=0 -> drained=1 after STAGES cycles.
//      With CNT_W=2, hold stall for 5 cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_interlock.sv
// Hazard/forwarding controller: tracks destination registers of in-flight instructions
// (EX..WB) and returns per-source forward selects plus a load-use stall for ID.
module pipe_interlock #(
    parameter int REG_AW   = 4,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2,
    parameter int ZERO_REG = 1,
    parameter int FLUSH_EX = 1,
    parameter int CNT_W    = 16,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     fwd_rs,
    output logic [SW-1:0]     fwd_rt,
    output logic              drained,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    logic [STAGES-1:0] ent_vld;
    logic [STAGES-1:0] ent_we;
    logic [STAGES-1:0] ent_ld;
    logic [REG_AW-1:0] ent_rd [STAGES];

    logic              rs_hit, rt_hit;
    logic              rs_rdy, rt_rdy;
    logic [SW-1:0]     rs_idx, rt_idx;
    logic              load0;
    logic [STAGES-1:0] vld_nxt;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_rdy = 1'b1;
        rt_rdy = 1'b1;
        rs_idx = '0;
        rt_idx = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (id_valid && id_rs_used && ent_vld[k] && ent_we[k] &&
                ent_rd[k] == id_rs && !is_zero_reg(id_rs)) begin
                rs_hit = 1'b1;
                rs_idx = SW'(k + 1);
                rs_rdy = !ent_ld[k] || (k >= LOAD_LAT - 1);
            end
            if (id_valid && id_rt_used && ent_vld[k] && ent_we[k] &&
                ent_rd[k] == id_rt && !is_zero_reg(id_rt)) begin
                rt_hit = 1'b1;
                rt_idx = SW'(k + 1);
                rt_rdy = !ent_ld[k] || (k >= LOAD_LAT - 1);
            end
        end
    end

    assign stall   = id_valid && !flush && ((rs_hit && !rs_rdy) || (rt_hit && !rt_rdy));
    assign fwd_rs  = rs_hit ? rs_idx : '0;
    assign fwd_rt  = rt_hit ? rt_idx : '0;
    assign drained = ~|ent_vld;
    assign load0   = id_valid && !stall && !flush;

    // A flush with FLUSH_EX also squashes the instruction currently in EX.
    always_comb begin
        vld_nxt    = '0;
        vld_nxt[0] = load0;
        for (int k = 1; k < STAGES; k++) begin
            vld_nxt[k] = ent_vld[k-1] && !((FLUSH_EX != 0) && (k == 1) && flush);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld   <= '0;
            stall_cnt <= '0;
        end else begin
            ent_vld <= vld_nxt;
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Entry payload is qualified by ent_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_rd[0] <= id_rd;
        ent_we[0] <= id_we;
        ent_ld[0] <= id_is_load;
        for (int k = 1; k < STAGES; k++) begin
            ent_rd[k] <= ent_rd[k-1];
            ent_we[k] <= ent_we[k-1];
            ent_ld[k] <= ent_ld[k-1];
        end
    end

endmodule

// File: tb/tb_pipe_interlock.sv
// Scoreboard bench for pipe_interlock: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against both DUT instances.
module tb_pipe_interlock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load, flush;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       stall, drained, s_stall, s_drained;
    logic [1:0] fwd_rs, fwd_rt, s_fwd_rs, s_fwd_rt;
    logic [15:0] stall_cnt;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    pipe_interlock dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_rs(fwd_rs),
        .fwd_rt(fwd_rt), .drained(drained), .stall_cnt(stall_cnt)
    );

    pipe_interlock #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(s_stall), .fwd_rs(s_fwd_rs),
        .fwd_rt(s_fwd_rt), .drained(s_drained), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        int    cyc;
        string nm;
        int    st, fr, ft, dr, cnt, sat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                cmp(e.nm, "stale", cyc, e.cyc);
            end else begin
                cmp(e.nm, "stall", int'(stall), e.st);
                cmp(e.nm, "fwd_rs", int'(fwd_rs), e.fr);
                cmp(e.nm, "fwd_rt", int'(fwd_rt), e.ft);
                cmp(e.nm, "drained", int'(drained), e.dr);
                cmp(e.nm, "stall_cnt", int'(stall_cnt), e.cnt);
                cmp(e.nm, "sat_stall_cnt", int'(s_stall_cnt), e.sat);
                cmp(e.nm, "sat_stall", int'(s_stall), e.st);
            end
        end
    end

    task automatic chk(input string nm, input int st, input int fr, input int ft, input int dr);
        exp_t e;
        e.cyc = cyc;
        e.nm  = nm;
        e.st  = st;
        e.fr  = fr;
        e.ft  = ft;
        e.dr  = dr;
        e.cnt = exp_cnt;
        e.sat = (exp_cnt > 3) ? 3 : exp_cnt;
        sb.push_back(e);
    endtask

    task automatic issue(input int v, input int rs, input int rsu, input int rt, input int rtu,
                         input int rd, input int we, input int ld, input int fl);
        @(posedge clk);
        #1;
        id_valid   = v[0];
        id_rs      = rs[3:0];
        id_rs_used = rsu[0];
        id_rt      = rt[3:0];
        id_rt_used = rtu[0];
        id_rd      = rd[3:0];
        id_we      = we[0];
        id_is_load = ld[0];
        flush      = fl[0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb.size());
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_rd = '0; id_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;

        @(posedge clk); #1;
        chk("reset", 0, 0, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reset_release", 0, 0, 0, 1);

        issue(1, 1, 1, 2, 1, 3, 1, 0, 0); chk("alu_first", 0, 0, 0, 1);
        issue(1, 3, 1, 5, 1, 4, 1, 0, 0); chk("alu_fwd_e0", 0, 1, 0, 0);
        issue(1, 3, 1, 4, 1, 0, 0, 0, 0); chk("alu_fwd_e1", 0, 2, 1, 0);

        issue(1, 1, 1, 2, 0, 2, 1, 1, 0); chk("lw_issue", 0, 0, 0, 0);
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0); chk("load_use_stall", 1, 1, 1, 0);
        exp_cnt++;
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0); chk("load_use_fwd", 0, 2, 2, 0);

        issue(1, 1, 1, 1, 1, 0, 1, 0, 0); chk("add_r0", 0, 0, 0, 0);
        issue(1, 0, 1, 0, 1, 8, 1, 0, 0); chk("use_r0", 0, 0, 0, 0);
        issue(1, 1, 1, 1, 1, 7, 1, 0, 0); chk("add_r7_a", 0, 0, 0, 0);
        issue(1, 1, 1, 1, 1, 7, 1, 0, 0); chk("add_r7_b", 0, 0, 0, 0);
        issue(1, 7, 1, 8, 1, 0, 0, 0, 0); chk("youngest_wins", 0, 1, 3, 0);

        issue(1, 1, 1, 0, 0, 2, 1, 1, 0); chk("lw_before_flush", 0, 0, 0, 0);
        issue(1, 2, 1, 0, 0, 9, 1, 0, 1); chk("flush_wins", 0, 1, 0, 0);
        issue(1, 2, 1, 0, 0, 0, 0, 0, 0); chk("after_flush", 0, 0, 0, 0);

        issue(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("drain_1", 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("drain_2", 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("drain_3", 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("drained", 0, 0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            issue(1, 9, 0, 9, 0, 5, 1, 1, 0); chk("sat_lw", 0, 0, 0, (i == 0) ? 1 : 0);
            issue(1, 5, 1, 9, 1, 9, 1, 0, 0); chk("sat_stall", 1, 1, (i == 0) ? 0 : 2, 0);
            exp_cnt++;
            issue(1, 5, 1, 9, 1, 9, 1, 0, 0); chk("sat_fwd", 0, 2, (i == 0) ? 0 : 3, 0);
        end

        issue(0, 9, 1, 0, 0, 0, 0, 0, 0); chk("idle_no_fwd", 0, 0, 0, 0);
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0); chk("lw_pre_reset", 0, 0, 0, 0);
        issue(1, 5, 1, 0, 0, 6, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mid_reset", 0, 0, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        id_valid = 1'b0;
        chk("post_reset", 0, 0, 0, 1);

        @(posedge clk);
        @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
